wb_regfile: RTL and testbench
=============================

# wb_regfile

Write-back stage and general-purpose register file for the pipelined MIPS core. Consumes the MEM/WB pipeline-register outputs, selects the destination register and the write-back value, and commits them to a 32×32 register file. Supplies the two combinational read ports used by the decode stage, with same-cycle write-through so no extra WB→ID forwarding path is needed. Also keeps a retired-write counter for debug.

## Interface
Parameters:
- NREG, 32, number of architectural registers (address width 5)
- DW, 32, data width

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- RegWr_W  in  1  write-enable from MEM/WB
- RegDst_W  in  1  1: destination Rd_W; 0: destination Rt_W
- MemtoReg_W  in  1  1: write dout_W; 0: write result_W
- NPCop_W  in  4  next-PC opcode; value NPC_JAL selects link write
- Rd_W  in  5  rd field
- Rt_W  in  5  rt field
- PC_W  in  32  PC of the instruction in WB
- result_W  in  32  ALU result
- dout_W  in  32  data-memory read data
- rs_addr  in  5  read port A address (decode stage)
- rt_addr  in  5  read port B address (decode stage)
- rs_data  out  32  read port A data
- rt_data  out  32  read port B data
- wb_en  out  1  effective write this cycle
- wb_addr  out  5  effective destination
- wb_data  out  32  effective write value
- wb_count  out  32  number of committed writes since reset

## Operation
- Destination: NPCop_W == NPC_JAL → 5'd31; else RegDst_W ? Rd_W : Rt_W.
- Value: NPCop_W == NPC_JAL → PC_W + 4 (mod 2^32); else MemtoReg_W ? dout_W : result_W.
- wb_en = RegWr_W && (wb_addr != 0). wb_addr, wb_data always driven by the selection above regardless of wb_en.
- Commit: on rising clk with wb_en=1, reg[wb_addr] ← wb_data. Register 0 has no storage; writes to it are dropped and it always reads 0.
- wb_count increments by 1 on each committed write (wb_en=1 at the edge); wraps 0xFFFFFFFF→0.
- Read ports (combinational, each independent): addr == 0 → 0; else wb_en && addr == wb_addr → wb_data (write-through); else reg[addr].
- Both ports reading the same address return identical data.

## Timing
- Reset (rst_n=0, asynchronous, takes effect immediately): all registers 1..31 ← 0, wb_count ← 0; consequently rs_data = rt_data = 0 while in reset unless write-through is active. Writes are blocked while rst_n=0.
- Reset released mid-stream: first commit occurs at the first rising edge with rst_n=1.
- Write latency: value visible on read ports in the same cycle it is presented (via bypass) and from stored array from the following cycle onward.
- Read ports: zero-cycle latency, purely combinational from rs_addr/rt_addr and WB inputs.
- wb_en/wb_addr/wb_data: combinational, same cycle as MEM/WB outputs.
- No stall or flush inputs; a bubble is represented by RegWr_W=0.

## Structure
- Shared package (cpu_pkg): NPC_JAL = 4'd3, other NPCop encodings, REG_RA = 5'd31, REG_ZERO = 5'd0, LINK_OFFSET = 32'd4.
- One sub-module, wb_select: combinational destination/value selection and wb_en; top level holds the array, counter, and read ports.

## Test plan
- Reset: assert rst_n=0 after writing reg5=0x1234 → rs_addr=5 reads 0, wb_count=0 immediately, before next clk.
- ALU write: RegWr=1, RegDst=1, Rd=8, MemtoReg=0, result=0xDEADBEEF → same cycle rs_addr=8 reads 0xDEADBEEF (bypass); next cycle with RegWr=0 still 0xDEADBEEF; wb_count=1.
- Load write: RegDst=0, Rt=9, MemtoReg=1, dout=0x0000CAFE, result=0x1 → reg9=0x0000CAFE; rt_addr=9 reads 0xCAFE.
- JAL: NPCop=NPC_JAL, PC_W=0x00400010, RegWr=1, Rd=4 → reg31=0x00400014, reg4 unchanged; PC_W=0xFFFFFFFC → reg31=0x00000000.
- Zero register: RegWr=1, Rd=0, result=0xFFFFFFFF → wb_en=0, rs_addr=0 reads 0, wb_count unchanged.
- Counter wrap and dual read: force 2^32-1 commits equivalent (preload via test hook or long run) → next write wraps wb_count to 0; rs_addr=rt_addr=8 return identical data.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared encodings for the pipelined MIPS core: next-PC opcodes, fixed
// register indices and the link offset used by jump-and-link.
package cpu_pkg;

    typedef enum logic [3:0] {
        NPC_PC4    = 4'd0,
        NPC_BRANCH = 4'd1,
        NPC_J      = 4'd2,
        NPC_JAL    = 4'd3,
        NPC_JR     = 4'd4
    } npc_op_e;

    localparam logic [4:0]  REG_ZERO    = 5'd0;
    localparam logic [4:0]  REG_RA      = 5'd31;
    localparam logic [31:0] LINK_OFFSET = 32'd4;

    function automatic logic is_link(input logic [3:0] npc_op);
        return npc_op == NPC_JAL;
    endfunction

endpackage

// File: rtl/wb_select.sv
// Write-back selection: picks the destination register and value from the
// MEM/WB outputs and qualifies the write enable.
module wb_select
    import cpu_pkg::*;
#(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 5
) (
    input  logic          RegWr_W,
    input  logic          RegDst_W,
    input  logic          MemtoReg_W,
    input  logic [3:0]    NPCop_W,
    input  logic [AW-1:0] Rd_W,
    input  logic [AW-1:0] Rt_W,
    input  logic [DW-1:0] PC_W,
    input  logic [DW-1:0] result_W,
    input  logic [DW-1:0] dout_W,
    output logic          wb_en,
    output logic [AW-1:0] wb_addr,
    output logic [DW-1:0] wb_data
);

    always_comb begin
        wb_addr = RegDst_W ? Rd_W : Rt_W;
        wb_data = MemtoReg_W ? dout_W : result_W;
        // Jump-and-link overrides both the instruction's own fields.
        if (is_link(NPCop_W)) begin
            wb_addr = AW'(REG_RA);
            wb_data = PC_W + DW'(LINK_OFFSET);
        end
        wb_en = RegWr_W && (wb_addr != AW'(REG_ZERO));
    end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage plus 32x32 register file with write-through read ports
// and a retired-write counter.
module wb_regfile
    import cpu_pkg::*;
#(
    parameter int unsigned NREG = 32,
    parameter int unsigned DW   = 32,
    localparam int unsigned AW  = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          RegWr_W,
    input  logic          RegDst_W,
    input  logic          MemtoReg_W,
    input  logic [3:0]    NPCop_W,
    input  logic [AW-1:0] Rd_W,
    input  logic [AW-1:0] Rt_W,
    input  logic [DW-1:0] PC_W,
    input  logic [DW-1:0] result_W,
    input  logic [DW-1:0] dout_W,
    input  logic [AW-1:0] rs_addr,
    input  logic [AW-1:0] rt_addr,
    output logic [DW-1:0] rs_data,
    output logic [DW-1:0] rt_data,
    output logic          wb_en,
    output logic [AW-1:0] wb_addr,
    output logic [DW-1:0] wb_data,
    output logic [31:0]   wb_count
);

    // Register 0 has no storage; the array starts at index 1.
    logic [DW-1:0] regs_q [1:NREG-1];
    logic [DW-1:0] regs_d [1:NREG-1];
    logic [31:0]   wb_count_q, wb_count_d;

    wb_select #(
        .DW(DW),
        .AW(AW)
    ) u_wb_select (
        .RegWr_W   (RegWr_W),
        .RegDst_W  (RegDst_W),
        .MemtoReg_W(MemtoReg_W),
        .NPCop_W   (NPCop_W),
        .Rd_W      (Rd_W),
        .Rt_W      (Rt_W),
        .PC_W      (PC_W),
        .result_W  (result_W),
        .dout_W    (dout_W),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data)
    );

    always_comb begin
        regs_d = regs_q;
        for (int i = 1; i < NREG; i++) begin
            if (wb_en && (wb_addr == AW'(i))) begin
                regs_d[i] = wb_data;
            end
        end
        wb_count_d = wb_count_q + 32'(wb_en);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            wb_count_q <= '0;
        end else begin
            regs_q     <= regs_d;
            wb_count_q <= wb_count_d;
        end
    end

    // Same-cycle bypass removes the need for a WB->ID forwarding path.
    // wb_en already excludes register 0, so address 0 always reads zero.
    always_comb begin
        rs_data = '0;
        rt_data = '0;
        for (int i = 1; i < NREG; i++) begin
            if (rs_addr == AW'(i)) rs_data = regs_q[i];
            if (rt_addr == AW'(i)) rt_data = regs_q[i];
        end
        if (wb_en && (rs_addr == wb_addr)) rs_data = wb_data;
        if (wb_en && (rt_addr == wb_addr)) rt_data = wb_data;
    end

    assign wb_count = wb_count_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: directed literal checks followed by random traffic
// compared every cycle against an array-based model of the register file.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        RegWr_W, RegDst_W, MemtoReg_W;
    logic [3:0]  NPCop_W;
    logic [4:0]  Rd_W, Rt_W, rs_addr, rt_addr;
    logic [31:0] PC_W, result_W, dout_W;
    logic [31:0] rs_data, rt_data, wb_data, wb_count;
    logic        wb_en;
    logic [4:0]  wb_addr;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    bit          chk_on = 1'b0;

    always #5 clk = ~clk;

    wb_regfile dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .RegWr_W   (RegWr_W),
        .RegDst_W  (RegDst_W),
        .MemtoReg_W(MemtoReg_W),
        .NPCop_W   (NPCop_W),
        .Rd_W      (Rd_W),
        .Rt_W      (Rt_W),
        .PC_W      (PC_W),
        .result_W  (result_W),
        .dout_W    (dout_W),
        .rs_addr   (rs_addr),
        .rt_addr   (rt_addr),
        .rs_data   (rs_data),
        .rt_data   (rt_data),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .wb_count  (wb_count)
    );

    // Reference model: plain array of 32 words and a commit counter.
    logic [31:0] m_regs [32];
    logic [31:0] m_count;
    logic        e_en;
    logic [4:0]  e_addr;
    logic [31:0] e_data;

    always_comb begin
        e_addr = (NPCop_W == 4'd3) ? 5'd31 : (RegDst_W ? Rd_W : Rt_W);
        e_data = (NPCop_W == 4'd3) ? PC_W + 32'd4 : (MemtoReg_W ? dout_W : result_W);
        e_en   = RegWr_W && (e_addr != 5'd0);
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) m_regs[i] <= 32'd0;
            m_count <= 32'd0;
        end else if (e_en) begin
            m_regs[e_addr] <= e_data;
            m_count        <= m_count + 32'd1;
        end
    end

    function automatic logic [31:0] exp_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (e_en && a == e_addr) return e_data;
        return m_regs[a];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check("wb_en", 32'(wb_en), 32'(e_en));
            check("wb_addr", 32'(wb_addr), 32'(e_addr));
            check("wb_data", wb_data, e_data);
            check("rs_data", rs_data, exp_read(rs_addr));
            check("rt_data", rt_data, exp_read(rt_addr));
            check("wb_count", wb_count, m_count);
        end
    end

    task automatic apply(input logic wr, input logic dst, input logic m2r, input logic [3:0] npc,
                         input logic [4:0] rd, input logic [4:0] rt, input logic [31:0] pc,
                         input logic [31:0] res, input logic [31:0] dout,
                         input logic [4:0] ra, input logic [4:0] rb);
        RegWr_W = wr; RegDst_W = dst; MemtoReg_W = m2r; NPCop_W = npc;
        Rd_W = rd; Rt_W = rt; PC_W = pc; result_W = res; dout_W = dout;
        rs_addr = ra; rt_addr = rb;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        apply(0, 0, 0, 4'd0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk_on = 1'b1;

        // Write reg5, then assert reset mid-cycle: contents and counter clear at once.
        apply(1, 1, 0, 4'd0, 5'd5, 5'd0, 0, 32'h1234, 0, 5'd5, 5'd0);
        next_cycle();
        apply(0, 0, 0, 4'd0, 0, 0, 0, 0, 0, 5'd5, 5'd0);
        #2 check("pre_reset_r5", rs_data, 32'h1234);
        rst_n = 1'b0;
        #1 check("reset_r5", rs_data, 32'd0);
        check("reset_count", wb_count, 32'd0);
        next_cycle();
        rst_n = 1'b1;

        // ALU write with bypass.
        apply(1, 1, 0, 4'd0, 5'd8, 5'd2, 0, 32'hDEADBEEF, 32'h5, 5'd8, 5'd0);
        #2 check("alu_bypass", rs_data, 32'hDEADBEEF);
        check("alu_wb_en", 32'(wb_en), 32'd1);
        next_cycle();
        apply(0, 0, 0, 4'd0, 0, 0, 0, 0, 0, 5'd8, 5'd8);
        #2 check("alu_stored", rs_data, 32'hDEADBEEF);
        check("alu_count", wb_count, 32'd1);
        check("dual_read", rt_data, rs_data);

        // Load write to rt.
        next_cycle();
        apply(1, 0, 1, 4'd0, 5'd3, 5'd9, 0, 32'h1, 32'h0000CAFE, 5'd0, 5'd9);
        next_cycle();
        apply(0, 0, 0, 4'd0, 0, 0, 0, 0, 0, 5'd0, 5'd9);
        #2 check("load_r9", rt_data, 32'h0000CAFE);
        check("load_count", wb_count, 32'd2);

        // JAL links to r31, ignores Rd.
        next_cycle();
        apply(1, 1, 0, 4'd3, 5'd4, 5'd0, 32'h00400010, 32'h77, 0, 5'd31, 5'd4);
        #2 check("jal_addr", 32'(wb_addr), 32'd31);
        check("jal_data", wb_data, 32'h00400014);
        next_cycle();
        apply(0, 0, 0, 4'd0, 0, 0, 0, 0, 0, 5'd31, 5'd4);
        #2 check("jal_r31", rs_data, 32'h00400014);
        check("jal_r4", rt_data, 32'd0);
        next_cycle();
        apply(1, 1, 0, 4'd3, 5'd4, 5'd0, 32'hFFFFFFFC, 0, 0, 5'd31, 5'd0);
        next_cycle();
        apply(0, 0, 0, 4'd0, 0, 0, 0, 0, 0, 5'd31, 5'd0);
        #2 check("jal_wrap", rs_data, 32'd0);
        check("jal_count", wb_count, 32'd4);

        // Writes to r0 are dropped.
        next_cycle();
        apply(1, 1, 0, 4'd0, 5'd0, 5'd0, 0, 32'hFFFFFFFF, 0, 5'd0, 5'd0);
        #2 check("r0_wb_en", 32'(wb_en), 32'd0);
        check("r0_read", rs_data, 32'd0);
        next_cycle();
        apply(0, 0, 0, 4'd0, 0, 0, 0, 0, 0, 5'd8, 5'd8);
        #2 check("r0_count", wb_count, 32'd4);
        check("dual_read2", rt_data, 32'hDEADBEEF);

        // Random traffic with occasional asynchronous reset pulses.
        for (int c = 0; c < 3000; c++) begin
            logic [4:0] rd, rt;
            next_cycle();
            rst_n = ($urandom_range(0, 299) != 0);
            rd = 5'($urandom);
            rt = 5'($urandom);
            apply(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
                  ($urandom_range(0, 3) == 0) ? 4'd3 : 4'($urandom_range(0, 4)),
                  rd, rt,
                  ($urandom_range(0, 15) == 0) ? 32'hFFFFFFFC : $urandom,
                  $urandom, $urandom,
                  ($urandom_range(0, 1) == 1) ? rd : 5'($urandom),
                  ($urandom_range(0, 1) == 1) ? rt : 5'($urandom_range(29, 31)));
        end

        next_cycle();
        rst_n = 1'b1;
        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
